// File: rtl/axi4lite_rtsnoc_bridge.sv
// axi4lite_rtsnoc_bridge: AXI4-Lite slave bridging to one RTSNoC router port with programmable TX destination and RX FIFO.
// Optional AXI4LITE_RTSNOC_IRQ_EN adds irq_o (registered rx_not_empty) and STATUS bit3.
module axi4lite_rtsnoc_bridge #(
  parameter int NOC_DATA_WIDTH = 32,
  parameter int NOC_LOCAL_ADR  = 0,
  parameter int NOC_X          = 0,
  parameter int NOC_Y          = 0,
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int RX_DEPTH_LOG2  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] axi_awaddr_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  output logic [1:0]  axi_bresp_o,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  input  logic [31:0] axi_araddr_i,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [NOC_DATA_WIDTH+2*SOC_SIZE_X+2*SOC_SIZE_Y+5:0] noc_din_o,
  output logic        noc_wr_o,
  input  logic        noc_wait_i,
  input  logic [NOC_DATA_WIDTH+2*SOC_SIZE_X+2*SOC_SIZE_Y+5:0] noc_dout_i,
  input  logic        noc_nd_i,
  output logic        noc_rd_o
`ifdef AXI4LITE_RTSNOC_IRQ_EN
  ,output logic       irq_o
`endif
);
  localparam int SX = SOC_SIZE_X;
  localparam int SY = SOC_SIZE_Y;
  localparam int DW = NOC_DATA_WIDTH;
  localparam int PW = DW + 2*SX + 2*SY + 6;
  localparam int AW = 3 + SX + SY;
  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int CW = RX_DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {W_IDLE, W_NOC, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [AW-1:0] tx_dst_q, tx_dst_d;
  logic [PW-1:0] din_q, din_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, wmask, status, rx_src;
  logic [CW-1:0] wp_q, wp_d, rp_q, rp_d, count;
  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [AW+DW-1:0] head;
  logic [AW-1:0] src;
  logic [2:0] widx, ridx;
  logic aw_acc, ar_acc, tx_go, push, pop, empty, full, irq, unused_ok;
  assign src = {SX'(NOC_X), SY'(NOC_Y), 3'(NOC_LOCAL_ADR)};
  assign widx = axi_awaddr_i[4:2];
  assign ridx = axi_araddr_i[4:2];
  assign aw_acc = (w_state_q == W_IDLE) && axi_awvalid_i && axi_wvalid_i;
  assign ar_acc = (r_state_q == R_IDLE) && axi_arvalid_i;
  assign tx_go = aw_acc && widx == 3'd1 && axi_wstrb_i == 4'hF;
  assign wmask = {{8{axi_wstrb_i[3]}}, {8{axi_wstrb_i[2]}}, {8{axi_wstrb_i[1]}}, {8{axi_wstrb_i[0]}}};
  assign count = wp_q - rp_q;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign push = noc_nd_i && !full;
  assign pop = ar_acc && ridx == 3'd2 && !empty;
  assign head = mem_q[rp_q[RX_DEPTH_LOG2-1:0]];
  // stored entry is {src_x, src_y, src_local, data}; RX_SRC repacks it like TX_DST
  assign rx_src = 32'({head[DW+3+:SY], head[DW+3+SY+:SX], head[DW+:3]});
  assign status = {16'd0, 8'(count), 4'd0, irq, w_state_q == W_NOC, full, !empty};
  assign unused_ok = ^{axi_awaddr_i[31:5], axi_awaddr_i[1:0], axi_araddr_i[31:5], axi_araddr_i[1:0], noc_dout_i[DW+AW-1:DW]};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      tx_dst_q <= '0;
      din_q <= '0;
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      tx_dst_q <= tx_dst_d;
      din_q <= din_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk_i)
    if (push) mem_q[wp_q[RX_DEPTH_LOG2-1:0]] <= {noc_dout_i[PW-1-:AW], noc_dout_i[DW-1:0]};
  always_comb begin
    w_state_d = (w_state_q == W_IDLE) ? (tx_go ? W_NOC : aw_acc ? W_RESP : W_IDLE)
              : (w_state_q == W_NOC)  ? (noc_wait_i ? W_NOC : W_RESP)
              : (axi_bready_i ? W_IDLE : W_RESP);
    r_state_d = (r_state_q == R_IDLE) ? (axi_arvalid_i ? R_RESP : R_IDLE)
              : (axi_rready_i ? R_IDLE : R_RESP);
  end
  always_comb begin
    tx_dst_d = (aw_acc && widx == 3'd0) ? AW'((32'(tx_dst_q) & ~wmask) | (axi_wdata_i & wmask)) : tx_dst_q;
    din_d = tx_go ? {src, tx_dst_q[3+:SX], tx_dst_q[3+SX+:SY], tx_dst_q[2:0], axi_wdata_i[DW-1:0]} : din_q;
    bresp_d = !aw_acc ? bresp_q : widx >= 3'd5 ? 2'b11 : (widx == 3'd1 && axi_wstrb_i != 4'hF) ? 2'b10 : 2'b00;
    rdata_d = !ar_acc ? rdata_q
            : ridx == 3'd0 ? 32'(tx_dst_q)
            : ridx == 3'd2 ? (empty ? 32'd0 : 32'(head[DW-1:0]))
            : ridx == 3'd3 ? (empty ? 32'd0 : rx_src)
            : ridx == 3'd4 ? status : 32'd0;
    rresp_d = !ar_acc ? rresp_q : ridx >= 3'd5 ? 2'b11 : (ridx == 3'd2 && empty) ? 2'b10 : 2'b00;
    wp_d = wp_q + CW'(push);
    rp_d = rp_q + CW'(pop);
  end
  assign axi_awready_o = aw_acc;
  assign axi_wready_o = aw_acc;
  assign axi_bvalid_o = w_state_q == W_RESP;
  assign axi_bresp_o = bresp_q;
  assign axi_arready_o = ar_acc;
  assign axi_rvalid_o = r_state_q == R_RESP;
  assign axi_rdata_o = rdata_q;
  assign axi_rresp_o = rresp_q;
  assign noc_wr_o = w_state_q == W_NOC;
  assign noc_din_o = din_q;
  assign noc_rd_o = push;
`ifdef AXI4LITE_RTSNOC_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) irq_q <= 1'b0;
    else irq_q <= !empty;
  assign irq = irq_q;
  assign irq_o = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_axi4lite_rtsnoc_bridge.sv
// tb_axi4lite_rtsnoc_bridge: directed + randomized checks of the AXI4-Lite to RTSNoC bridge against a queue-based model.
module tb_axi4lite_rtsnoc_bridge;
  localparam int DW = 32, SX = 1, SY = 1, PW = DW + 2*SX + 2*SY + 6, DEPTH = 4;
  localparam int LADR = 5, NX = 1, NY = 0;
`ifdef AXI4LITE_RTSNOC_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, noc_wr, noc_rd;
  logic noc_wait = 0, noc_nd = 0;
  logic [1:0] bresp, rresp;
  logic [PW-1:0] noc_din, noc_dout = 0;
  logic irq;
  int checks = 0, errors = 0, hold = 0, waited = 0;
  typedef struct {int x; int y; int l; logic [31:0] d;} ent_t;
  ent_t q[$];

  axi4lite_rtsnoc_bridge #(.NOC_LOCAL_ADR(LADR), .NOC_X(NX), .NOC_Y(NY)) dut (
    .clk_i(clk), .rst_i(rst),
    .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_araddr_i(araddr), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .noc_din_o(noc_din), .noc_wr_o(noc_wr), .noc_wait_i(noc_wait),
    .noc_dout_i(noc_dout), .noc_nd_i(noc_nd), .noc_rd_o(noc_rd)
`ifdef AXI4LITE_RTSNOC_IRQ_EN
    , .irq_o(irq)
`endif
  );
`ifndef AXI4LITE_RTSNOC_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  // router model: stalls the first `hold` edges of every TX packet
  always @(negedge clk) begin
    if (!noc_wr) begin waited = 0; noc_wait = 0; end
    else begin noc_wait = (waited < hold); waited++; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input int sx, sy, sl, dx, dy, dl, input logic [31:0] d);
    return {SX'(sx), SY'(sy), 3'(sl), SX'(dx), SY'(dy), 3'(dl), DW'(d)};
  endfunction

  function automatic logic [31:0] exp_status(input bit busy);
    int n = q.size();
    return (n << 8) | (32'(IRQ && n != 0) << 3) | (32'(busy) << 2) | (32'(n == DEPTH) << 1) | 32'(n != 0);
  endfunction

  task automatic axi_write(input logic [31:0] a, d, input logic [3:0] s, output logic [1:0] resp,
                           output int lat, output int wrc, output logic [PW-1:0] din, output bit stable);
    int n = 0;
    @(negedge clk); awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0; #1;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    chk("aw_w_accept", {awready, wready}, 2'b11);
    @(posedge clk); @(negedge clk); awvalid = 0; wvalid = 0; #1;
    lat = 1; wrc = 0; stable = 1; din = '0;
    while (!bvalid && lat < 50) begin
      if (noc_wr) begin
        if (wrc == 0) din = noc_din; else if (noc_din !== din) stable = 0;
        wrc++;
      end
      @(negedge clk); #1; lat++;
    end
    resp = bresp; bready = 1;
    @(posedge clk); @(negedge clk); bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk); araddr = a; arvalid = 1; rready = 0; #1;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); @(negedge clk); arvalid = 0; #1; n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
    d = rdata; r = rresp; rready = 1;
    @(posedge clk); @(negedge clk); rready = 0;
  endtask

  task automatic noc_send(input logic [PW-1:0] p, output bit ok);
    int n = 0;
    @(negedge clk); noc_dout = p; noc_nd = 1; #1;
    while (!noc_rd && n < 50) begin @(negedge clk); #1; n++; end
    ok = noc_rd;
    @(posedge clk); @(negedge clk); noc_nd = 0;
  endtask

  initial begin
    logic [1:0] resp, rr;
    logic [31:0] rd;
    logic [PW-1:0] din;
    int lat, wrc;
    bit stable, ok;
    ent_t e;
    logic [4:0] dst;
    repeat (2) @(negedge clk); #1;
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 0);
    chk("rst_noc", {noc_din, noc_wr, noc_rd}, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk); rst = 0;

    axi_write(32'h0, 32'h0B, 4'hF, resp, lat, wrc, din, stable);
    chk("dst_wr_resp", resp, 0);
    chk("dst_wr_lat", lat, 1);
    axi_read(32'h0, rd, rr);
    chk("dst_rd", {rr, rd}, {2'b00, 32'h0B});
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, resp, lat, wrc, din, stable);
    chk("tx_din", din, pkt(NX, NY, LADR, 1, 0, 3, 32'hDEADBEEF));
    chk("tx_wr_cycles", wrc, 1);
    chk("tx_lat", lat, 2);
    chk("tx_resp", resp, 0);

    hold = 5;
    fork
      axi_write(32'h4, 32'hDEADBEEF, 4'hF, resp, lat, wrc, din, stable);
      begin repeat (3) @(negedge clk); axi_read(32'h10, rd, rr); end
    join
    hold = 0;
    chk("stall_wr_cycles", wrc, 6);
    chk("stall_stable", stable, 1);
    chk("stall_lat", lat, 7);
    chk("stall_din", din, pkt(NX, NY, LADR, 1, 0, 3, 32'hDEADBEEF));
    chk("stall_status", {rr, rd}, {2'b00, exp_status(1)});

    for (int i = 1; i <= DEPTH; i++) begin
      e = '{x: $urandom_range(0, 1), y: $urandom_range(0, 1), l: $urandom_range(0, 7), d: 32'(i)};
      noc_send(pkt(e.x, e.y, e.l, NX, NY, LADR, e.d), ok);
      q.push_back(e);
    end
    axi_read(32'h10, rd, rr);
    chk("full_status", rd, exp_status(0));
    e = '{x: 1, y: 1, l: 6, d: 32'd5};
    fork
      noc_send(pkt(e.x, e.y, e.l, NX, NY, LADR, e.d), ok);
      begin
        repeat (2) @(negedge clk); #1;
        chk("rd_while_full", noc_rd, 0);
        axi_read(32'h8, rd, rr);
      end
    join
    chk("full_pop0", {rr, rd}, {2'b00, q.pop_front().d});
    chk("fifth_accepted", ok, 1);
    q.push_back(e);
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(32'h8, rd, rr);
      chk("fifo_order", {rr, rd}, {2'b00, q.pop_front().d});
    end

    axi_read(32'h8, rd, rr);
    chk("empty_rx_data", {rr, rd}, {2'b10, 32'd0});
    axi_read(32'hC, rd, rr);
    chk("empty_rx_src", {rr, rd}, {2'b00, 32'd0});
    axi_read(32'h18, rd, rr);
    chk("decerr_rd", {rr, rd}, {2'b11, 32'd0});
    axi_write(32'h1C, 32'hFFFFFFFF, 4'hF, resp, lat, wrc, din, stable);
    chk("decerr_wr", {resp, 8'(wrc)}, {2'b11, 8'd0});
    axi_write(32'h4, 32'h12345678, 4'h3, resp, lat, wrc, din, stable);
    chk("partial_tx_resp", resp, 2'b10);
    chk("partial_tx_nowr", wrc, 0);

    for (int i = 0; i < 3; i++) begin
      dst = 5'($urandom_range(0, 31));
      hold = $urandom_range(0, 3);
      axi_write(32'h0, 32'(dst), 4'hF, resp, lat, wrc, din, stable);
      axi_read(32'h0, rd, rr);
      chk("rand_dst_rd", rd, 32'(dst));
      rd = $urandom;
      axi_write(32'hFFFF_FF04, rd, 4'hF, resp, lat, wrc, din, stable);
      chk("rand_tx_din", din, pkt(NX, NY, LADR, dst[3], dst[4], dst[2:0], rd));
      chk("rand_tx_timing", {lat, wrc}, {hold + 2, hold + 1});
    end
    hold = 0;
    axi_write(32'h0, 32'hFFFFFFFF, 4'h2, resp, lat, wrc, din, stable);
    axi_read(32'h0, rd, rr);
    chk("strobe_byte1", rd, 32'(dst));
    axi_write(32'h0, 32'hFFFFFFE0, 4'h1, resp, lat, wrc, din, stable);
    axi_read(32'h0, rd, rr);
    chk("strobe_byte0", rd, 0);

    for (int i = 0; i < 3; i++) begin
      e = '{x: $urandom_range(0, 1), y: $urandom_range(0, 1), l: $urandom_range(0, 7), d: $urandom};
      noc_send(pkt(e.x, e.y, e.l, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), e.d), ok);
      q.push_back(e);
      axi_read(32'hC, rd, rr);
      chk("rx_src", {rr, rd}, {2'b00, 32'((q[0].y << 4) | (q[0].x << 3) | q[0].l)});
      axi_read(32'h8, rd, rr);
      chk("rx_data", {rr, rd}, {2'b00, q.pop_front().d});
    end

    for (int i = 0; i < 2; i++) begin
      e = '{x: i, y: 1 - i, l: i + 2, d: $urandom};
      noc_send(pkt(e.x, e.y, e.l, NX, NY, LADR, e.d), ok);
      q.push_back(e);
    end
    e = '{x: 1, y: 1, l: 7, d: $urandom};
    fork
      noc_send(pkt(e.x, e.y, e.l, NX, NY, LADR, e.d), ok);
      axi_read(32'h8, rd, rr);
    join
    chk("pushpop_data", {rr, rd}, {2'b00, q.pop_front().d});
    q.push_back(e);
    axi_read(32'h10, rd, rr);
    chk("pushpop_count", rd, exp_status(0));
    chk("irq_level", irq, IRQ);

    hold = 1000;
    @(negedge clk); awaddr = 32'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); @(negedge clk); awvalid = 0; wvalid = 0; #1;
    chk("abort_wr_before", noc_wr, 1);
    #2 rst = 1; #1;
    chk("abort_wr_async", noc_wr, 0);
    @(negedge clk); rst = 0; hold = 0; q.delete(); bready = 1;
    repeat (3) @(negedge clk); #1;
    chk("abort_no_bvalid", bvalid, 0);
    bready = 0;
    axi_read(32'h10, rd, rr);
    chk("abort_status", rd, exp_status(0));
    chk("abort_irq", irq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
